spi_cfg_master: RTL and testbench
=================================

Name: spi_cfg_master

Overview:
Mode-0 SPI controller that drives configuration frames into the team's SPI register-file peripheral (ui_in[0]=sclk, ui_in[1]=copi, ui_in[2]=nCS).
- Accepts register-write requests from on-chip logic through a valid/ready port.
- Buffers requests in a small FIFO.
- Serializes each request as one 16-bit frame, MSB first: {rw, addr[6:0], data[7:0]}.
- Paces sclk and inter-frame nCS gaps slowly enough for the peripheral's 2-FF synchronizers and edge detectors.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period; legal range >=2, elaboration error otherwise
CS_GAP, 8, clk cycles nCS held high between frames; legal range >=4, elaboration error otherwise
FIFO_DEPTH, 4, request FIFO entries; power of 2, >=2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  FIFO not full; transfer on clk edge when req_valid && req_ready
req_rw  input  1  frame bit 15 (1=write)
req_addr  input  7  frame bits 14:8
req_data  input  8  frame bits 7:0
spi_sclk  output  1  serial clock, idle low
spi_copi  output  1  serial data, MSB first
spi_ncs  output  1  chip select, active low
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  entries currently buffered
frames_sent  output  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset (async, immediate): spi_sclk=0, spi_copi=0, spi_ncs=1, busy=0, fifo_level=0, frames_sent=0, req_ready=1, FSM=IDLE. FIFO contents are flushed. All outputs are registered.
- FIFO:
  - req_ready = (fifo_level != FIFO_DEPTH), combinational from the registered level.
  - Push and pop in the same cycle leave the level unchanged.
  - No push occurs when full. No pop occurs when empty.
- FSM states: IDLE, SETUP, HIGH, LOW, HOLD, GAP. A down-counter of width $clog2(max(CLK_DIV,CS_GAP))+1 times each phase. A 5-bit bit counter counts sclk high phases.
- IDLE: if the FIFO is non-empty, pop into the 16-bit shift register. On that edge: spi_ncs<=0, spi_copi<=frame[15], go to SETUP.
  - A request accepted at edge N into an empty FIFO while IDLE produces spi_ncs low after edge N+1.
- SETUP: sclk low for CLK_DIV cycles, then sclk<=1 and go to HIGH.
- HIGH: sclk high for CLK_DIV cycles, then sclk<=0 and bit_count++.
  - If 16 bits are done, go to HOLD.
  - Otherwise shift left, spi_copi<=next bit, go to LOW.
- LOW: CLK_DIV cycles, then sclk<=1, go to HIGH.
- HOLD: sclk low for CLK_DIV cycles with ncs low. Then spi_ncs<=1, frames_sent++, go to GAP.
- GAP: ncs high for CS_GAP cycles, then go to IDLE. The next frame may start on the following edge.
- Frame timing:
  - spi_ncs is low for exactly 33*CLK_DIV cycles.
  - Exactly 16 sclk rising edges per frame.
  - copi changes only on the edge that sets ncs low or on an sclk falling edge, never while sclk is high.
- Back-to-back frames: minimum ncs-high time between frames is CS_GAP+1 cycles (GAP plus the IDLE cycle).
- rw=0 frames are transmitted identically; the peripheral ignores them.
- Reset mid-frame: ncs returns high asynchronously. The partial frame (<16 bits) is discarded by the peripheral, and frames_sent is not incremented.
- No frame is ever truncated or extended by req_valid activity.

Test Plan:
1. Reset values: assert rst_n=0 with random inputs -> spi_ncs=1, spi_sclk=0, spi_copi=0, req_ready=1, busy=0, fifo_level=0, frames_sent=0.
2. Single write {1,0x04,0x80}, CLK_DIV=4, peripheral attached:
   - copi bits sampled at 16 sclk rises = 0x8480.
   - ncs low for 132 cycles; frames_sent=1.
   - peripheral pwm_duty_cycle=0x80; other registers remain 0x00.
3. Burst: req_valid held with 6 distinct writes (addr 0x00..0x03, 0x00, 0x01):
   - req_ready drops once fifo_level=4.
   - Requests are accepted in order, frames appear in order.
   - Each ncs-high gap is >=9 cycles.
   - Peripheral holds the data of the last write to each address.
4. Async reset asserted after the 8th sclk rise of a write to addr 0x00 data 0xFF:
   - spi_ncs=1 immediately, FIFO empty.
   - Peripheral en_reg_out_7_0 stays 0x00; frames_sent=0.
5. Read frame {0,0x02,0x55} -> 16 sclk edges emitted, frames_sent increments, peripheral registers unchanged.
6. Send 257 frames -> frames_sent reads 0x01 (wrapped); busy=0 and fifo_level=0 after the final GAP.

Source files
------------

// File: rtl/spi_cfg_master.sv
// spi_cfg_master
//
// Mode-0 SPI controller that pushes 16-bit configuration frames
// {rw, addr[6:0], data[7:0]} (MSB first) into the SPI register-file
// peripheral. Requests arrive on a valid/ready port and are buffered in a small
// FIFO. sclk half-periods and the inter-frame nCS gap are stretched so the
// peripheral's 2-FF synchronizers and edge detectors can follow.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    FIFO not full; a request transfers when req_valid && req_ready
//   req_rw       frame bit 15 (1 = write)
//   req_addr     frame bits 14:8
//   req_data     frame bits 7:0
//   spi_sclk     serial clock, idle low
//   spi_copi     serial data, MSB first
//   spi_ncs      chip select, active low
//   busy         FIFO non-empty or FSM not idle
//   fifo_level   entries currently buffered
//   frames_sent  completed-frame counter, wraps 255 -> 0

module spi_cfg_master #(
    parameter int CLK_DIV    = 4,
    parameter int CS_GAP     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rw,
    input  logic [6:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          spi_sclk,
    output logic                          spi_copi,
    output logic                          spi_ncs,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    frames_sent
);

    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXP = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] DIV_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(CS_GAP - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_cfg_master: CLK_DIV must be >= 2");
    end
    if (CS_GAP < 4) begin : g_bad_cs_gap
        $error("spi_cfg_master: CS_GAP must be >= 4");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_cfg_master: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } state_e;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   fifo_head;
    logic          push;
    logic          pop;

    assign req_ready = (level_q != LVL_FULL);
    assign push      = req_valid && req_ready;
    assign fifo_head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !push) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {req_rw, req_addr, req_data};
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic          sclk_q, sclk_d;
    logic          ncs_q, ncs_d;
    logic [7:0]    frames_q, frames_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sclk_d    = sclk_q;
        ncs_d     = ncs_q;
        frames_d  = frames_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The registered level is used, so a request pushed on this
                // edge is picked up on the next one.
                if (level_q != '0) begin
                    pop       = 1'b1;
                    shift_d   = fifo_head;
                    ncs_d     = 1'b0;
                    bit_cnt_d = '0;
                    cnt_d     = DIV_LOAD;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LOAD;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    cnt_d     = DIV_LOAD;
                    if (bit_cnt_q == 5'd15) begin
                        state_d = StHold;
                    end else begin
                        // copi is the shift MSB, so it only moves on sclk fall.
                        shift_d = {shift_q[14:0], 1'b0};
                        state_d = StLow;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StLow: begin
                if (cnt_q == '0) begin
                    sclk_d  = 1'b1;
                    cnt_d   = DIV_LOAD;
                    state_d = StHigh;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    ncs_d    = 1'b1;
                    frames_d = frames_q + 1'b1;
                    cnt_d    = GAP_LOAD;
                    state_d  = StGap;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
            frames_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sclk_q    <= sclk_d;
            ncs_q     <= ncs_d;
            frames_q  <= frames_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    assign spi_sclk    = sclk_q;
    assign spi_copi    = shift_q[15];
    assign spi_ncs     = ncs_q;
    assign busy        = (level_q != '0) || (state_q != StIdle);
    assign fifo_level  = level_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master. A pin-level monitor decodes frames the way the
// register-file peripheral does and scores them against a queue of requested
// frames; a 128-byte array stands in for the peripheral's registers.

module tb_spi_cfg_master;

    localparam int CLK_DIV    = 4;
    localparam int CS_GAP     = 8;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       spi_sclk;
    logic       spi_copi;
    logic       spi_ncs;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] frames_sent;

    spi_cfg_master #(
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .spi_sclk    (spi_sclk),
        .spi_copi    (spi_copi),
        .spi_ncs     (spi_ncs),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference state
    logic [15:0] exp_q[$];
    logic [7:0]  exp_regs [128];
    logic [7:0]  periph [128];
    int          n_acc = 0;

    // Monitor state
    logic        prev_ncs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_copi = 1'b0;
    logic        in_frame = 1'b0;
    logic        had_frame = 1'b0;
    int          rises = 0;
    int          low_cnt = 0;
    int          gap_cnt = 0;
    int          frames_seen = 0;
    logic [15:0] shreg = '0;
    logic [15:0] last_frame = '0;

    always @(negedge clk) begin
        logic [15:0] want;
        if (!rst_n) begin
            in_frame  = 1'b0;
            had_frame = 1'b0;
            rises     = 0;
        end else begin
            if (prev_ncs && !spi_ncs) begin
                if (had_frame) begin
                    check("ncs_gap_min", 32'(gap_cnt >= CS_GAP + 1), 32'd1);
                end
                in_frame = 1'b1;
                rises    = 0;
                low_cnt  = 0;
                shreg    = '0;
            end
            if (!spi_ncs) low_cnt++;
            if (spi_sclk && !prev_sclk) begin
                if (spi_ncs) check("sclk_rise_with_ncs_low", 32'(spi_ncs), 32'd0);
                rises++;
                shreg = {shreg[14:0], spi_copi};
            end
            if (spi_sclk && prev_sclk && (spi_copi != prev_copi)) begin
                check("copi_stable_while_sclk_high", 32'(spi_copi), 32'(prev_copi));
            end
            if (!prev_ncs && spi_ncs && in_frame) begin
                check("sclk_rises_per_frame", 32'(rises), 32'd16);
                check("ncs_low_cycles", 32'(low_cnt), 32'(33 * CLK_DIV));
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(shreg), 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    check("frame_order", 32'(shreg), 32'(want));
                end
                if (rises == 16 && shreg[15]) periph[shreg[14:8]] = shreg[7:0];
                last_frame = shreg;
                frames_seen++;
                in_frame  = 1'b0;
                had_frame = 1'b1;
                gap_cnt   = 1;
            end else if (spi_ncs) begin
                gap_cnt++;
            end
        end
        prev_ncs  = spi_ncs;
        prev_sclk = spi_sclk;
        prev_copi = spi_copi;
    end

    task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d,
                        output int waited);
        waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && waited < 5000) begin
            if (waited == 0) check("full_level_when_not_ready", 32'(fifo_level), 32'(FIFO_DEPTH));
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            exp_q.push_back({rw, a, d});
            if (rw) exp_regs[a] = d;
            n_acc++;
            @(posedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((busy || !spi_ncs) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", 32'(busy || !spi_ncs), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        n_acc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 128; i++) begin
            periph[i]   = 8'h00;
            exp_regs[i] = 8'h00;
        end
    endtask

    function automatic int reg_mismatches();
        int m = 0;
        for (int i = 0; i < 128; i++) if (periph[i] !== exp_regs[i]) m++;
        return m;
    endfunction

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_frame;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int   w;
        int   nz;
        int   seen0;

        vecs[0] = '{rw: 1'b1, addr: 7'h04, data: 8'h80, exp_frame: 16'h8480};
        vecs[1] = '{rw: 1'b0, addr: 7'h02, data: 8'h55, exp_frame: 16'h0255};
        vecs[2] = '{rw: 1'b1, addr: 7'h7F, data: 8'hFF, exp_frame: 16'hFFFF};
        vecs[3] = '{rw: 1'b1, addr: 7'h00, data: 8'h00, exp_frame: 16'h8000};
        clear_regs();

        // Reset values with random inputs
        rst_n     = 1'b0;
        req_valid = 1'($urandom_range(1, 0));
        req_rw    = 1'($urandom_range(1, 0));
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
        #23;
        check("rst_ncs", 32'(spi_ncs), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_copi", 32'(spi_copi), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_frames", 32'(frames_sent), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        // Table-driven single frames
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].rw, vecs[i].addr, vecs[i].data, w);
            wait_idle(1000);
            check("vec_frame", 32'(last_frame), 32'(vecs[i].exp_frame));
            check("vec_frames_sent", 32'(frames_sent), 32'(i + 1));
            if (i == 0) begin
                check("pwm_duty_written", 32'(periph[4]), 32'h80);
                nz = 0;
                for (int r = 0; r < 128; r++) if (r != 4 && periph[r] != 8'h00) nz++;
                check("other_regs_zero", 32'(nz), 32'd0);
            end
            if (i == 1) check("read_frame_no_write", 32'(periph[2]), 32'h00);
        end
        check("table_regs", 32'(reg_mismatches()), 32'd0);

        // Burst of six back-to-back writes
        begin
            logic [6:0] ba [6];
            logic [7:0] bd [6];
            ba = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h00, 7'h01};
            bd = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            for (int i = 0; i < 6; i++) begin
                send(1'b1, ba[i], bd[i], w);
                if (i < 5) check("burst_accept_no_wait", 32'(w), 32'd0);
                else       check("burst_sixth_waits", 32'(w > 0), 32'd1);
            end
            wait_idle(3000);
            check("burst_reg0", 32'(periph[0]), 32'h55);
            check("burst_reg1", 32'(periph[1]), 32'h66);
            check("burst_reg2", 32'(periph[2]), 32'h33);
            check("burst_reg3", 32'(periph[3]), 32'h44);
            check("burst_frames_sent", 32'(frames_sent), 32'(n_acc % 256));
        end

        // Asynchronous reset in the middle of a frame
        clear_regs();
        send(1'b1, 7'h00, 8'hFF, w);
        begin
            int n = 0;
            @(negedge clk);
            req_valid = 1'b0;
            while (!(in_frame && rises >= 8) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("abort_reached_8_rises", 32'(in_frame && rises >= 8), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ncs", 32'(spi_ncs), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_level", 32'(fifo_level), 32'd0);
        check("abort_frames", 32'(frames_sent), 32'd0);
        exp_q.delete();
        n_acc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_stays_idle", 32'({busy, spi_ncs}), 32'b01);
        check("abort_frames_after", 32'(frames_sent), 32'd0);
        check("abort_en_reg_untouched", 32'(periph[0]), 32'h00);
        clear_regs();

        // Randomized traffic against the reference model
        for (int i = 0; i < 24; i++) begin
            int gap = $urandom_range(3, 0);
            if (gap != 0) idle_cycles(gap);
            send(1'($urandom_range(1, 0)), 7'($urandom_range(7, 0)), 8'($urandom), w);
        end
        wait_idle(6000);
        check("rand_frames_sent", 32'(frames_sent), 32'(n_acc % 256));
        check("rand_regs", 32'(reg_mismatches()), 32'd0);
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

        // 257 frames: counter wraps
        do_reset();
        seen0 = frames_seen;
        for (int i = 0; i < 257; i++) begin
            send(1'b1, 7'($urandom_range(127, 0)), 8'($urandom), w);
        end
        wait_idle(2000);
        check("wrap_frames_sent", 32'(frames_sent), 32'h01);
        check("wrap_frames_seen", 32'(frames_seen - seen0), 32'd257);
        check("wrap_busy", 32'(busy), 32'd0);
        check("wrap_level", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
